// File: rtl/sinepwm_3ph_ctrl.sv
// Three-phase sine PWM duty generator.
// A prescaled tick drives a step counter whose interval ramps between
// START_INTERVAL and the requested |freq|. Each step moves the table index
// one position in the latched direction. A shared-port ROM sequencer then
// produces the three phase duties, which are 120 degrees (10 entries) apart.
module sinepwm_3ph_ctrl #(
  parameter int unsigned DIVIDER        = 1000,
  parameter int unsigned START_INTERVAL = 1000,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [31:0] freq,
  output logic [7:0]         duty_a,
  output logic [7:0]         duty_b,
  output logic [7:0]         duty_c,
  output logic               running,
  output logic               dir_out,
  output logic [1:0]         state_out
);

  localparam logic [31:0] DIV_W   = 32'(DIVIDER);
  localparam logic [31:0] START_W = 32'(START_INTERVAL);
  localparam logic [31:0] RAMP_W  = 32'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2
  } state_e;

  // One quantised sine period, 30 entries centred on 128.
  function automatic logic [7:0] sine_lut(input logic [4:0] a);
    case (a)
      5'd0:    return 8'd128;
      5'd1:    return 8'd153;
      5'd2:    return 8'd177;
      5'd3:    return 8'd199;
      5'd4:    return 8'd217;
      5'd5:    return 8'd232;
      5'd6:    return 8'd242;
      5'd7:    return 8'd247;
      5'd8:    return 8'd247;
      5'd9:    return 8'd242;
      5'd10:   return 8'd232;
      5'd11:   return 8'd217;
      5'd12:   return 8'd199;
      5'd13:   return 8'd177;
      5'd14:   return 8'd153;
      5'd15:   return 8'd128;
      5'd16:   return 8'd103;
      5'd17:   return 8'd79;
      5'd18:   return 8'd57;
      5'd19:   return 8'd39;
      5'd20:   return 8'd24;
      5'd21:   return 8'd14;
      5'd22:   return 8'd9;
      5'd23:   return 8'd9;
      5'd24:   return 8'd14;
      5'd25:   return 8'd24;
      5'd26:   return 8'd39;
      5'd27:   return 8'd57;
      5'd28:   return 8'd79;
      5'd29:   return 8'd103;
      default: return 8'd128;
    endcase
  endfunction

  // Table index addition modulo 30 (both operands already below 30).
  function automatic logic [4:0] idx_add(input logic [4:0] base, input logic [4:0] off);
    logic [5:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 6'd30) s = s - 6'd30;
    return s[4:0];
  endfunction

  // Move cur one RAMP_STEP toward tgt, saturating at tgt (never overshoots, never wraps).
  function automatic logic [31:0] ramp_toward(input logic [31:0] cur, input logic [31:0] tgt);
    if (cur > tgt)      return ((cur - tgt) > RAMP_W) ? (cur - RAMP_W) : tgt;
    else if (cur < tgt) return ((tgt - cur) > RAMP_W) ? (cur + RAMP_W) : tgt;
    else                return cur;
  endfunction

  // Lengthen the interval by RAMP_STEP, saturating at START_INTERVAL.
  function automatic logic [31:0] ramp_decel(input logic [31:0] cur);
    if (cur >= START_W)                return START_W;
    else if ((START_W - cur) > RAMP_W) return cur + RAMP_W;
    else                               return START_W;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] tick_cnt_q;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] cur_int_q, cur_int_d;
  logic [4:0]  idx_q, idx_d;
  logic        dir_q, dir_d;

  logic [2:0]  lk_ph_q;
  logic [4:0]  lk_base_q;
  logic [4:0]  rd_addr;
  logic [7:0]  rom_q;
  logic [7:0]  hold_a_q, hold_b_q;

  logic [31:0] freq_u, tmag, step_inc, start_int;
  logic        tdir, tick, run_ok, req_ok, step_fire;
  logic [4:0]  idx_step, lk_idx;
  logic        start_go, enter_idle, lk_start;

  assign freq_u    = $unsigned(freq);
  assign tmag      = freq[31] ? (~freq_u + 32'd1) : freq_u;
  assign tdir      = freq[31];
  assign req_ok    = enable && (tmag != 32'd0);
  assign run_ok    = req_ok && (tdir == dir_q);
  assign tick      = (tick_cnt_q == 32'd0);
  assign step_inc  = step_cnt_q + 32'd1;
  assign step_fire = tick && (state_q != ST_IDLE) && (step_inc >= cur_int_q);
  assign idx_step  = dir_q ? ((idx_q == 5'd0) ? 5'd29 : idx_q - 5'd1)
                           : ((idx_q == 5'd29) ? 5'd0 : idx_q + 5'd1);
  assign start_int = (tmag > START_W) ? tmag : START_W;
  assign dir_out   = dir_q;

  // Free-running prescaler: reload at zero, tick while at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick ? DIV_W : (tick_cnt_q - 32'd1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: RUN/DECEL exit and resume are checked every clock, the stop decision only on a step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_ok) state_d = ST_RUN;
      ST_RUN:   if (!run_ok) state_d = ST_DECEL;
      ST_DECEL: begin
        if (run_ok)                                  state_d = ST_RUN;
        else if (step_fire && (cur_int_q >= START_W)) state_d = req_ok ? ST_RUN : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and the control strobes derived from the transition.
  always_comb begin
    running    = (state_q != ST_IDLE);
    state_out  = state_q;
    start_go   = (state_q == ST_IDLE) && (state_d == ST_RUN);
    enter_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    lk_start   = start_go || (step_fire && (state_d != ST_IDLE));
    lk_idx     = start_go ? idx_q : idx_step;
  end

  // Next values of the step counter, interval, table index and direction.
  always_comb begin
    step_cnt_d = step_cnt_q;
    cur_int_d  = cur_int_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    if (state_q == ST_IDLE) begin
      step_cnt_d = '0;
      cur_int_d  = start_go ? start_int : START_W;
      if (start_go) dir_d = tdir;
    end else if (state_d == ST_IDLE) begin
      // Only a DECEL step leads here; the index still advances on it.
      step_cnt_d = '0;
      cur_int_d  = START_W;
      idx_d      = idx_step;
    end else begin
      if (tick) step_cnt_d = step_fire ? 32'd0 : step_inc;
      if (step_fire) begin
        idx_d     = idx_step;
        cur_int_d = ((state_q == ST_RUN) && run_ok) ? ramp_toward(cur_int_q, tmag)
                                                     : ramp_decel(cur_int_q);
      end
      // A DECEL that has reached the slow interval may restart in the requested direction.
      if ((state_q == ST_DECEL) && (state_d == ST_RUN)) dir_d = tdir;
    end
  end

  // Step counter, interval, index and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      cur_int_q  <= START_W;
      idx_q      <= '0;
      dir_q      <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      cur_int_q  <= cur_int_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
    end
  end

  // ROM address for the current lookup phase: idx, idx+10, idx+20 (mod 30).
  always_comb begin
    case (lk_ph_q)
      3'd2:    rd_addr = idx_add(lk_base_q, 5'd10);
      3'd3:    rd_addr = idx_add(lk_base_q, 5'd20);
      default: rd_addr = lk_base_q;
    endcase
  end

  // Synchronous single read port plus holding registers for phases A and B.
  always_ff @(posedge clk) begin
    rom_q <= sine_lut(rd_addr);
    if (lk_ph_q == 3'd2) hold_a_q <= rom_q;
    if (lk_ph_q == 3'd3) hold_b_q <= rom_q;
  end

  // Lookup sequencer: phases 1-3 read, phase 4 commits all three duties at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_ph_q   <= 3'd0;
      lk_base_q <= '0;
      duty_a    <= '0;
      duty_b    <= '0;
      duty_c    <= '0;
    end else if (enter_idle) begin
      lk_ph_q <= 3'd0;
      duty_a  <= '0;
      duty_b  <= '0;
      duty_c  <= '0;
    end else begin
      if (lk_ph_q == 3'd4) begin
        duty_a <= hold_a_q;
        duty_b <= hold_b_q;
        duty_c <= rom_q;
      end
      if (lk_start) begin
        lk_ph_q   <= 3'd1;
        lk_base_q <= lk_idx;
      end else if (lk_ph_q != 3'd0) begin
        lk_ph_q <= (lk_ph_q == 3'd4) ? 3'd0 : (lk_ph_q + 3'd1);
      end
    end
  end

endmodule

// File: doc/sinepwm_3ph_ctrl.md
SINEPWM_3PH_CTRL -- requirements
Module: sinepwm_3ph_ctrl

Interface
REQ-001 Parameter DIVIDER, default 1000: tick prescaler; one tick every DIVIDER+1 clk; SHALL be at least 3.
REQ-002 Parameter START_INTERVAL, default 1000: slowest step interval in ticks, used at start and stop.
REQ-003 Parameter RAMP_STEP, default 1: interval change in ticks applied per step while ramping.
REQ-004 Port clk, input, 1: sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port enable, input, 1: run request.
REQ-007 Port freq, input, signed 32: target step interval in ticks; sign selects direction (negative = reverse); 0 = stop.
REQ-008 Ports duty_a, duty_b, duty_c, output, 8 each: phase duty values for the PWM stages.
REQ-009 Port running, output, 1: high when state is not IDLE.
REQ-010 Port dir_out, output, 1: latched direction; 1 = reverse.
REQ-011 Port state_out, output, 2: IDLE=0, RUN=1, DECEL=2.

Function
REQ-012 Tick counter SHALL reload DIVIDER at 0 and otherwise decrement; tick SHALL be a 1-clk pulse when the count is 0.
REQ-013 tmag = |freq| as 32-bit unsigned; -2^31 SHALL map to 0x8000_0000; tdir = freq<0.
REQ-014 Sine table: 30 entries, 8 bit: 128,153,177,199,217,232,242,247,247,242,232,217,199,177,153,128,103,79,57,39,24,14,9,9,14,24,39,57,79,103.
REQ-015 IDLE->RUN when enable=1 and tmag!=0: dir<=tdir; cur_int<=max(START_INTERVAL,tmag); step_cnt<=0; one lookup SHALL start at the current idx.
REQ-016 In RUN/DECEL, step_cnt SHALL increment on each tick; when the incremented value equals or exceeds cur_int, a step SHALL fire and step_cnt SHALL clear, so the interval is cur_int ticks.
REQ-017 On a step, idx SHALL advance by +1 (dir=0) or -1 (dir=1), wrapping 29->0 and 0->29; a lookup SHALL start with the new idx.
REQ-018 RUN ramp, on each step: if cur_int>tmag, cur_int<=max(tmag,cur_int-RAMP_STEP); if cur_int<tmag, cur_int<=min(tmag,cur_int+RAMP_STEP).
REQ-019 RUN->DECEL when enable=0, or tmag=0, or tdir!=dir; this SHALL be evaluated every clk.
REQ-020 DECEL, on each step: cur_int<=min(START_INTERVAL,cur_int+RAMP_STEP).
REQ-021 DECEL->RUN without a stop when enable=1, tmag!=0 and tdir=dir.
REQ-022 DECEL step at which the pre-step cur_int>=START_INTERVAL, with enable=1 and tmag!=0: go to RUN with dir<=tdir; otherwise go to IDLE.
REQ-023 Lookup SHALL be a 3-clk sequencer sharing one table read port: cycle 1 reads idx, cycle 2 reads (idx+10) mod 30, cycle 3 reads (idx+20) mod 30.
REQ-024 duty_a/b/c SHALL update together on the clk after the third read, never individually.
REQ-025 Entering IDLE SHALL zero all duties on that same edge and abort any lookup in progress.
REQ-026 In IDLE, idx and dir SHALL hold; step_cnt=0; cur_int=START_INTERVAL.
REQ-027 All arithmetic SHALL be 32-bit unsigned on cur_int and step_cnt; no wrap beyond START_INTERVAL or below 1.

Reset
REQ-028 rst=1 SHALL asynchronously force: state IDLE, duties 0, idx 0, dir 0, step_cnt 0, tick counter 0, cur_int=START_INTERVAL, lookup idle, running 0.
REQ-029 Release of rst SHALL take effect on the next clk edge; a start SHALL require enable=1 and freq!=0 sampled after release.

Verification (DIVIDER=3, START_INTERVAL=8, RAMP_STEP=2)
REQ-030 enable=1, freq=2 from reset -> RUN; 4 clk later duty a/b/c=128/232/24; step intervals in ticks 8,6,4,2,2; idx 1,2,3,...
REQ-031 In RUN forward at interval 2, set freq=-2 -> DECEL; intervals grow 4,6,8; then RUN with dir_out=1, idx decrementing, intervals 6,4,2.
REQ-032 Running forward with idx reaching 29 -> duties 103/242/39; next step idx=0 -> 128/232/24.
REQ-033 From RUN at interval 2, drop enable -> DECEL, intervals 4,6,8; then IDLE, duties 0, running 0, idx held.
REQ-034 enable=1, freq=20 -> cur_int=20 immediately, every interval 20 ticks, no ramp.
REQ-035 Assert rst mid-lookup in RUN -> duties, running and state_out go to 0 before the next clk edge; no duty update follows after release.
